// File: rtl/seq_pkg.sv
// seq_pkg: state encodings shared by the serial bit feeder and the sequence detector.
package seq_pkg;

    localparam int STAT_W = 2;

    // Feeder FSM encoding, visible on the feeder's stat port.
    typedef enum logic [STAT_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LAST  = 2'b10
    } feed_state_e;

    // Detector FSM encoding; kept here so both blocks agree on stat width and meaning.
    typedef enum logic [STAT_W-1:0] {
        DET_S0   = 2'b00,
        DET_S1   = 2'b01,
        DET_S11  = 2'b10,
        DET_S110 = 2'b11
    } det_state_e;

endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: DIV-cycle bit-period divider producing a registered one-cycle tick.
//   clk         rising-edge clock
//   clr_n       asynchronous active-low reset
//   restart     a word is accepted this cycle; next cycle starts a fresh bit period
//   active_next the feeder will be shifting in the next cycle
//   tick        high in the last cycle of each bit period
module bit_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic restart,
    input  logic active_next,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // cnt_q is the index of the current cycle within its bit period, so the
    // registered tick is computed from the count the next cycle will hold.
    always_comb begin
        cnt_d  = (restart || !active_next || cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        tick_d = active_next && (cnt_d == CW'(DIV - 1));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: serializes parallel words over valid/ready into a gapless bit stream.
//   clk         rising-edge clock
//   clr_n       asynchronous active-low reset
//   load_data   parallel word to serialize
//   load_valid  load_data is valid
//   load_ready  a word is accepted on this edge if load_valid is high
//   dout        serial bit stream, held DIV cycles per bit
//   dout_valid  high in the last cycle of each bit period
//   busy        a word is being shifted
//   stat        FSM state (00 IDLE, 01 SHIFT, 10 LAST)
module serial_bit_feeder
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   DIV        = 1,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [1:0]       stat
);

    localparam int BW = $clog2(WIDTH);

    feed_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             dout_q, dout_d;
    logic             tick, accept, advance, active_d;

    assign accept   = load_valid && load_ready;
    assign advance  = (state_q == ST_SHIFT) && tick;
    assign active_d = (state_d != ST_IDLE);

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk        (clk),
        .clr_n      (clr_n),
        .restart    (accept),
        .active_next(active_d),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = (tick && bit_cnt_q == BW'(WIDTH - 2)) ? ST_LAST : ST_SHIFT;
            ST_LAST:  state_d = accept ? ST_SHIFT : tick ? ST_IDLE : ST_LAST;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Ready opens during the final cycle of the last bit so a new word chains with no gap.
    always_comb begin
        load_ready = (state_q == ST_IDLE) || (state_q == ST_LAST && tick);
        busy       = (state_q != ST_IDLE);
        stat       = state_q;
    end

    // dout is registered from the next-cycle shift register so the first bit
    // appears in the cycle right after the accepting edge.
    always_comb begin
        bit_cnt_d = (accept || !active_d) ? '0 : advance ? bit_cnt_q + 1'b1 : bit_cnt_q;
        sr_d      = accept ? load_data : !active_d ? '0 :
                    advance ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
        dout_d    = active_d ? (MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0]) : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            dout_q    <= IDLE_LEVEL;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = tick;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: scoreboard plus table-driven and directed checks for serial_bit_feeder.
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       r0, r1, r2, o0, o1, o2, ov0, ov1, ov2, b0, b1, b2;
    logic [1:0] s0, s1, s2;

    int total = 0;
    int passed = 0;
    bit q0[$];
    bit q1[$];
    bit q2[$];

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .clr_n(clr_n), .load_data(d0), .load_valid(v0), .load_ready(r0),
        .dout(o0), .dout_valid(ov0), .busy(b0), .stat(s0));
    serial_bit_feeder #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .clr_n(clr_n), .load_data(d1), .load_valid(v1), .load_ready(r1),
        .dout(o1), .dout_valid(ov1), .busy(b1), .stat(s1));
    serial_bit_feeder #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (
        .clk(clk), .clr_n(clr_n), .load_data(d2), .load_valid(v2), .load_ready(r2),
        .dout(o2), .dout_valid(ov2), .busy(b2), .stat(s2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int u, input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            case (u)
                0:       q0.push_back(w[7-i]);
                1:       q1.push_back(w[7-i]);
                default: q2.push_back(w[i]);
            endcase
    endtask

    always @(negedge clk) if (clr_n && ov0) begin
        if (q0.size() == 0) begin
            total++;
            $display("FAIL u0_extra_bit: got dout=%0b want no bit", o0);
        end else chk("u0_bit", o0, q0.pop_front());
    end
    always @(negedge clk) if (clr_n && ov1) begin
        if (q1.size() == 0) begin
            total++;
            $display("FAIL u1_extra_bit: got dout=%0b want no bit", o1);
        end else chk("u1_bit", o1, q1.pop_front());
    end
    always @(negedge clk) if (clr_n && ov2) begin
        if (q2.size() == 0) begin
            total++;
            $display("FAIL u2_extra_bit: got dout=%0b want no bit", o2);
        end else chk("u2_bit", o2, q2.pop_front());
    end

    task automatic send0(input logic [7:0] w);
        int n = 0;
        v0 = 1'b1;
        d0 = w;
        while (!r0 && n < 50) begin
            step();
            n++;
        end
        if (!r0) begin
            total++;
            $display("FAIL send0_timeout: got ready=0 want 1");
            v0 = 1'b0;
        end else begin
            push(0, w);
            step();
            v0 = 1'b0;
        end
    endtask

    task automatic drain0();
        int n = 0;
        while (b0 && n < 60) begin
            step();
            n++;
        end
        chk("u0_drain_busy", b0, 0);
        chk("u0_drain_queue", q0.size(), 0);
        chk("u0_idle_stat", s0, 2'b00);
        chk("u0_idle_dout", o0, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         gap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] a5;
        logic [7:0] ob;
        vecs[0] = '{8'hD0, 0};
        vecs[1] = '{8'h0D, 3};
        vecs[2] = '{8'hFF, 1};
        vecs[3] = '{8'h00, 0};
        vecs[4] = '{8'h5A, 2};
        vecs[5] = '{8'h81, 0};
        a5 = 8'hA5;
        ob = 8'h0B;

        #12;
        chk("rst_ready", r0, 1);
        chk("rst_dout", o0, 0);
        chk("rst_dvalid", ov0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_stat", s0, 2'b00);
        chk("rst_busy_u1", b1, 0);
        @(posedge clk);
        #1 clr_n = 1'b1;
        step();
        chk("post_rst_ready", r0, 1);

        // back-to-back D0 then 0D with valid held
        v0 = 1'b1;
        d0 = 8'hD0;
        push(0, 8'hD0);
        step();
        chk("first_bit_dout", o0, 1);
        for (int k = 1; k <= 8; k++) begin
            chk("b2b_ready_w1", r0, (k == 8));
            chk("b2b_stat_w1", s0, (k == 8) ? 2'b10 : 2'b01);
            chk("b2b_dvalid", ov0, 1);
            if (k == 8) begin
                d0 = 8'h0D;
                push(0, 8'h0D);
            end
            step();
        end
        v0 = 1'b0;
        for (int k = 9; k <= 16; k++) begin
            chk("b2b_busy_w2", b0, 1);
            chk("b2b_ready_w2", r0, (k == 16));
            step();
        end
        chk("b2b_end_busy", b0, 0);
        chk("b2b_end_stat", s0, 2'b00);
        chk("b2b_queue", q0.size(), 0);

        // DIV=3, A5
        v1 = 1'b1;
        d1 = a5;
        push(1, a5);
        step();
        v1 = 1'b0;
        d1 = 8'h00;
        for (int k = 0; k < 24; k++) begin
            chk("div3_busy", b1, 1);
            chk("div3_dvalid", ov1, (k % 3 == 2));
            chk("div3_dout", o1, a5[7 - k / 3]);
            step();
        end
        chk("div3_end_busy", b1, 0);
        chk("div3_end_stat", s1, 2'b00);
        chk("div3_queue", q1.size(), 0);

        // LSB first, 0B -> 1,1,0,1,0,0,0,0
        v2 = 1'b1;
        d2 = ob;
        push(2, ob);
        step();
        v2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("lsb_dout", o2, ob[k]);
            step();
        end
        chk("lsb_end_busy", b2, 0);
        chk("lsb_queue", q2.size(), 0);

        // reset mid-word after 3 bits of FF
        send0(8'hFF);
        step();
        step();
        step();
        chk("midrst_pre_busy", b0, 1);
        clr_n = 1'b0;
        #1;
        chk("midrst_dout", o0, 0);
        chk("midrst_busy", b0, 0);
        chk("midrst_stat", s0, 2'b00);
        chk("midrst_dvalid", ov0, 0);
        q0.delete();
        step();
        step();
        clr_n = 1'b1;
        step();
        chk("midrst_ready", r0, 1);
        chk("midrst_after_busy", b0, 0);

        // valid pulse while busy is ignored
        send0(8'h3C);
        step();
        step();
        step();
        v0 = 1'b1;
        d0 = 8'hFF;
        chk("pulse_ready", r0, 0);
        step();
        v0 = 1'b0;
        for (int k = 5; k <= 8; k++) begin
            chk("pulse_ready_tail", r0, (k == 8));
            step();
        end
        drain0();

        // table-driven stream
        for (int i = 0; i < 6; i++) begin
            send0(vecs[i].data);
            for (int g = 0; g < vecs[i].gap; g++) step();
        end
        drain0();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
